// File: rtl/axis_output_arbiter_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream output arbiter.
// Carries the AXIS beat/handshake structs, the arbiter state enum and the round-robin pick.
package axis_output_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int DEST_WIDTH = 4;
  localparam int USER_WIDTH = 4;
  localparam int MAX_INPUTS = 16;
  localparam int PTR_W      = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  typedef struct packed {
    logic       tvalid;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Request bits above the real input count are zero, so wrapping modulo MAX_INPUTS
  // picks the same winner as wrapping modulo the actual input count.
  function automatic logic [MAX_INPUTS-1:0] rr_pick(input logic [MAX_INPUTS-1:0] req,
                                                    input logic [PTR_W-1:0]      ptr);
    logic [MAX_INPUTS-1:0] gnt;
    logic [PTR_W-1:0]      idx;
    gnt = '0;
    for (int k = MAX_INPUTS - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/axis_output_arbiter_if.sv
// Bundle of all competing queue streams, their fill flags and the single forwarded stream.
// master is the arbiter's view; slave is the surrounding queues plus downstream link.
interface axis_output_arbiter_if #(
  parameter int N_INPUTS = 5
);
  import axis_output_arbiter_pkg::*;

  axis_mosi_t [N_INPUTS-1:0] in_mosi;
  axis_miso_t [N_INPUTS-1:0] in_miso;
  logic       [N_INPUTS-1:0] half_full;
  axis_mosi_t                out_mosi;
  axis_miso_t                out_miso;

  modport master (
    input  in_mosi, half_full, out_miso,
    output in_miso, out_mosi
  );

  modport slave (
    output in_mosi, half_full, out_miso,
    input  in_miso, out_mosi
  );

endinterface

// File: rtl/axis_output_arbiter_rr_priority_picker.sv
// Round-robin picker: first request at or after the pointer wins, result is one-hot.
module axis_output_arbiter_rr_priority_picker
  import axis_output_arbiter_pkg::*;
#(
  parameter int N_INPUTS = 5
) (
  input  logic [N_INPUTS-1:0] req_i,
  input  logic [PTR_W-1:0]    ptr_i,
  output logic [N_INPUTS-1:0] gnt_o
);

  logic [MAX_INPUTS-1:0] gnt_full;

  always_comb gnt_full = rr_pick(MAX_INPUTS'(req_i), ptr_i);

  assign gnt_o = gnt_full[N_INPUTS-1:0];

  generate
    if (N_INPUTS < MAX_INPUTS) begin : g_hi
      logic unused_hi;
      assign unused_hi = |gnt_full[MAX_INPUTS-1:N_INPUTS];
    end
  endgenerate

endmodule

// File: rtl/axis_output_arbiter.sv
// Packet-level round-robin arbiter for one output port with half-full priority boost.
// A grant is held until TLAST; granted beats go through one registered output stage.
module axis_output_arbiter
  import axis_output_arbiter_pkg::*;
#(
  parameter int N_INPUTS  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axis_output_arbiter_if.master bus,
  output logic [N_INPUTS-1:0]   grant_o,
  output logic                  locked_o,
  output logic [CNT_WIDTH-1:0]  pkt_count_o
);

  arb_state_t           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_INPUTS-1:0]  grant_q, grant_d;
  logic                 out_vld_q, out_vld_d;
  axis_data_t           out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [N_INPUTS-1:0]  valid_vec, boost_req, boost_gnt, norm_gnt;
  logic [N_INPUTS-1:0]  idle_win, owner_oh, ready_vec;
  logic                 load, xfer;
  axis_data_t           sel_data;
  logic [PTR_W-1:0]     win_idx;

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) valid_vec[i] = bus.in_mosi[i].tvalid;
    boost_req = valid_vec & bus.half_full;
  end

  axis_output_arbiter_rr_priority_picker #(.N_INPUTS(N_INPUTS)) u_pick_boost (
    .req_i (boost_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (boost_gnt)
  );

  axis_output_arbiter_rr_priority_picker #(.N_INPUTS(N_INPUTS)) u_pick_norm (
    .req_i (valid_vec),
    .ptr_i (rr_ptr_q),
    .gnt_o (norm_gnt)
  );

  // While locked, grant_q is the stored owner; in IDLE the combinational winner owns the port.
  always_comb begin
    load      = !out_vld_q || bus.out_miso.tready;
    idle_win  = (|boost_req) ? boost_gnt : norm_gnt;
    owner_oh  = (state_q == LOCKED) ? grant_q : idle_win;
    ready_vec = load ? owner_oh : '0;
    xfer      = |(ready_vec & valid_vec);
    sel_data  = '0;
    win_idx   = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (owner_oh[i]) sel_data = bus.in_mosi[i].data;
      if (idle_win[i]) win_idx  = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && !sel_data.tlast) state_d = LOCKED;
      LOCKED:  if (xfer &&  sel_data.tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) bus.in_miso[i].tready = ready_vec[i];
    locked_o = (state_q == LOCKED);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && xfer)
      rr_ptr_d = (win_idx == PTR_W'(N_INPUTS - 1)) ? '0 : win_idx + PTR_W'(1);

    if (xfer)                 grant_d = owner_oh;
    else if (state_q == IDLE) grant_d = '0;
    else                      grant_d = grant_q;

    if (xfer)                    out_vld_d = 1'b1;
    else if (bus.out_miso.tready) out_vld_d = 1'b0;
    else                         out_vld_d = out_vld_q;

    out_data_d = xfer ? sel_data : out_data_q;

    pkt_cnt_d = pkt_cnt_q;
    if (xfer && sel_data.tlast && pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      out_vld_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      out_vld_q <= out_vld_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_ff @(posedge clk_i) out_data_q <= out_data_d;

  always_comb begin
    bus.out_mosi.tvalid = out_vld_q;
    bus.out_mosi.data   = out_data_q;
    grant_o             = grant_q;
    pkt_count_o         = pkt_cnt_q;
  end

endmodule

// File: tb/tb_axis_output_arbiter.sv
// Directed bench for the output arbiter: rotation, locking, gaps, boost, stall, saturation, reset.
module tb_axis_output_arbiter;
  import axis_output_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  grant;
  logic          locked;
  logic [CW-1:0] pkt_count;
  int            n_chk  = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  axis_output_arbiter_if #(.N_INPUTS(N)) bus ();

  axis_output_arbiter #(.N_INPUTS(N), .CNT_WIDTH(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .grant_o     (grant),
    .locked_o    (locked),
    .pkt_count_o (pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] d, input logic l);
    bus.in_mosi[i].tvalid     = v;
    bus.in_mosi[i].data.tdata = d;
    bus.in_mosi[i].data.tid   = 4'(i);
    bus.in_mosi[i].data.tdest = 4'h1;
    bus.in_mosi[i].data.tuser = 4'h0;
    bus.in_mosi[i].data.tlast = l;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdy();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = bus.in_miso[i].tready;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    clear_all();
    bus.half_full       = '0;
    bus.out_miso.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  32'(bus.out_mosi.tvalid), 32'h0);
    chk("rst_grant",  32'(grant),  32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_pkt",    32'(pkt_count), 32'h0);
    rst = 1'b0;

    // Single-beat packets from every input: grants rotate 0..4,0.
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'(i * 16), 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1 chk("rot_ready", rdy(), 32'(1 << (k % N)));
      tick();
      chk("rot_grant", 32'(grant), 32'(1 << (k % N)));
      chk("rot_data",  bus.out_mosi.data.tdata, 32'((k % N) * 16));
    end
    clear_all();
    chk("rot_pkt", 32'(pkt_count), 32'd6);
    tick();
    chk("idle_valid", 32'(bus.out_mosi.tvalid), 32'h0);
    chk("idle_grant", 32'(grant), 32'h0);

    // 4-beat packet from input 2 while input 0 waits (rr_ptr is 1).
    drive(0, 1'b1, 32'h0F, 1'b1);
    for (int b = 0; b < 4; b++) begin
      drive(2, 1'b1, 32'(32'h20 + b), (b == 3));
      #1 chk("lock_ready", rdy(), 32'b00100);
      tick();
      chk("lock_data",   bus.out_mosi.data.tdata, 32'(32'h20 + b));
      chk("lock_grant",  32'(grant), 32'b00100);
      chk("lock_locked", 32'(locked), (b < 3) ? 32'h1 : 32'h0);
    end
    drive(2, 1'b0, 32'h0, 1'b0);
    tick();
    chk("after_data",  bus.out_mosi.data.tdata, 32'h0F);
    chk("after_grant", 32'(grant), 32'b00001);
    clear_all();
    tick();

    // Owner gap: input 1 pauses mid-packet, input 3 must wait (rr_ptr is 1).
    drive(1, 1'b1, 32'h10, 1'b0);
    drive(3, 1'b1, 32'h3F, 1'b1);
    #1 chk("gap_ready0", rdy(), 32'b00010);
    tick();
    chk("gap_d0", bus.out_mosi.data.tdata, 32'h10);
    drive(1, 1'b1, 32'h11, 1'b0);
    tick();
    chk("gap_d1", bus.out_mosi.data.tdata, 32'h11);
    drive(1, 1'b0, 32'h0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      #1 chk("gap_ready", rdy(), 32'b00010);
      tick();
      chk("gap_valid",  32'(bus.out_mosi.tvalid), 32'h0);
      chk("gap_grant",  32'(grant), 32'b00010);
      chk("gap_locked", 32'(locked), 32'h1);
    end
    drive(1, 1'b1, 32'h12, 1'b1);
    tick();
    chk("gap_last", bus.out_mosi.data.tdata, 32'h12);
    chk("gap_unlock", 32'(locked), 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0);
    #1 chk("gap_ready3", rdy(), 32'b01000);
    tick();
    chk("gap_d3", bus.out_mosi.data.tdata, 32'h3F);
    chk("gap_g3", 32'(grant), 32'b01000);
    clear_all();
    tick();

    // Pointer wraps 4 -> 0, then half-full boost lets input 4 beat input 0.
    drive(4, 1'b1, 32'h40, 1'b1);
    tick();
    chk("wrap_data", bus.out_mosi.data.tdata, 32'h40);
    drive(4, 1'b1, 32'h41, 1'b1);
    drive(0, 1'b1, 32'h01, 1'b1);
    bus.half_full = 5'b10000;
    #1 chk("boost_ready", rdy(), 32'b10000);
    tick();
    chk("boost_data", bus.out_mosi.data.tdata, 32'h41);
    drive(4, 1'b0, 32'h0, 1'b0);
    bus.half_full = '0;
    #1 chk("boost_ready0", rdy(), 32'b00001);
    tick();
    chk("boost_d0", bus.out_mosi.data.tdata, 32'h01);
    clear_all();
    tick();

    // Downstream stall: empty stage still loads, then holds for 5 cycles (rr_ptr is 1).
    bus.out_miso.tready = 1'b0;
    drive(2, 1'b1, 32'h25, 1'b1);
    drive(3, 1'b1, 32'h35, 1'b1);
    #1 chk("stall_ready0", rdy(), 32'b00100);
    tick();
    drive(2, 1'b0, 32'h0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      #1 chk("stall_ready", rdy(), 32'h0);
      tick();
      chk("stall_data",  bus.out_mosi.data.tdata, 32'h25);
      chk("stall_valid", 32'(bus.out_mosi.tvalid), 32'h1);
    end
    bus.out_miso.tready = 1'b1;
    #1 chk("stall_ready3", rdy(), 32'b01000);
    tick();
    chk("stall_d3", bus.out_mosi.data.tdata, 32'h35);
    chk("stall_v3", 32'(bus.out_mosi.tvalid), 32'h1);
    clear_all();
    tick();
    chk("stall_drain", 32'(bus.out_mosi.tvalid), 32'h0);
    chk("pkt_15", 32'(pkt_count), 32'd15);

    // Counter saturates at all-ones.
    drive(0, 1'b1, 32'h0A, 1'b1);
    tick();
    chk("sat_data", bus.out_mosi.data.tdata, 32'h0A);
    chk("sat_pkt",  32'(pkt_count), 32'd15);
    clear_all();
    tick();

    // Reset in the middle of a packet from input 1.
    drive(1, 1'b1, 32'h1A, 1'b0);
    tick();
    chk("pre_rst_locked", 32'(locked), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid",  32'(bus.out_mosi.tvalid), 32'h0);
    chk("mid_rst_grant",  32'(grant), 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_pkt",    32'(pkt_count), 32'h0);
    rst = 1'b0;
    drive(0, 1'b1, 32'h0B, 1'b1);
    drive(1, 1'b1, 32'h1B, 1'b1);
    tick();
    chk("post_rst_grant", 32'(grant), 32'b00001);
    chk("post_rst_data",  bus.out_mosi.data.tdata, 32'h0B);
    clear_all();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
